// File: rtl/multdiv_ctrl_pkg.sv
// ============================================================================
//  Module      : multdiv_ctrl_pkg
//  Description : Shared state encoding and constants for the multdiv
//                sequencing controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [4:0]  OPCODE_RTYPE = 5'b00000;
  localparam logic [4:0]  ALUOP_MULT   = 5'b00110;
  localparam logic [4:0]  ALUOP_DIV    = 5'b00111;

  localparam logic [4:0]  RSTATUS_REG  = 5'd30;
  localparam logic [31:0] EXC_MULT     = 32'd4;
  localparam logic [31:0] EXC_DIV      = 32'd5;

  localparam logic [5:0]  TIMEOUT      = 6'd63;

endpackage

`default_nettype wire

// File: rtl/multdiv_ctrl.sv
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : Sequences a multi-cycle mult/div: stalls the core, pulses the
//                unit start, waits for the result (with timeout) and writes it
//                back. Define MULTDIV_EXC_EN to redirect exceptions to r30.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluOp,
  input  logic [4:0]  rd,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic [4:0]  r_rd;
  logic        r_is_div;
  logic [31:0] r_result;
  logic        r_exc;

  logic        w_is_mult;
  logic        w_is_div;
  logic        w_decode;
  logic [5:0]  w_cnt_inc;
  logic        w_timeout;

  assign w_is_mult = (opcode == OPCODE_RTYPE) && (aluOp == ALUOP_MULT);
  assign w_is_div  = (opcode == OPCODE_RTYPE) && (aluOp == ALUOP_DIV);
  assign w_decode  = w_is_mult || w_is_div;
  assign w_cnt_inc = r_cnt + 6'd1;
  // Timeout fires on the WAIT cycle in which the counter reaches its limit
  assign w_timeout = (w_cnt_inc == TIMEOUT);

`ifndef MULTDIV_EXC_EN
  logic w_unused_exc;
  assign w_unused_exc = r_exc;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_rd     <= '0;
      r_is_div <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_decode) begin
            r_rd     <= rd;
            r_is_div <= w_is_div;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (md_ready) begin
            r_result <= md_result;
            r_exc    <= md_exception;
          end else if (w_timeout) begin
            r_result <= '0;
            r_exc    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    wb_en        = 1'b0;
    wb_reg       = '0;
    wb_data      = '0;
    case (r_state)
      S_IDLE: begin
        stall = w_decode;
        if (w_decode) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        stall        = 1'b1;
        ctrl_MULT    = ~r_is_div;
        ctrl_DIV     = r_is_div;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (md_ready || w_timeout) w_state_next = S_WB;
      end
      S_WB: begin
        w_state_next = S_IDLE;
        wb_en        = (r_rd != 5'd0);
        wb_reg       = r_rd;
        wb_data      = r_result;
`ifdef MULTDIV_EXC_EN
        if (r_exc) begin
          wb_en   = 1'b1;
          wb_reg  = RSTATUS_REG;
          wb_data = r_is_div ? EXC_DIV : EXC_MULT;
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
    // Outputs are held quiet for the whole reset cycle, not just after it
    if (!reset) begin
      stall     = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      wb_en     = 1'b0;
      wb_reg    = '0;
      wb_data   = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
// ============================================================================
//  Module      : tb_multdiv_ctrl
//  Description : Self-checking bench for multdiv_ctrl with a transaction-level
//                reference model; honours MULTDIV_EXC_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  opcode;
  logic [4:0]  aluOp;
  logic [4:0]  rd;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  multdiv_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .aluOp        (aluOp),
    .rd           (rd),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .md_result    (md_result),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall        (stall),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data)
  );

  // kind: 0 = unrelated instruction, 1 = mult, 2 = div
  task automatic drive_instr(input int kind, input logic [4:0] r);
    opcode = 5'b00000;
    rd     = r;
    case (kind)
      1:       aluOp = 5'b00110;
      2:       aluOp = 5'b00111;
      default: aluOp = 5'b00000;
    endcase
  endtask

  // Reference: what one mult/div instruction must write back.
  // n_ready = WAIT cycle on which the result arrives, 0 = never (timeout).
  task automatic model_wb(input bit is_div, input logic [4:0] r, input int n_ready,
                          input bit exc, input logic [31:0] res,
                          output bit en, output logic [4:0] reg_o, output logic [31:0] data);
    bit          exc_eff;
    logic [31:0] res_eff;
    exc_eff = (n_ready == 0) ? 1'b1 : exc;
    res_eff = (n_ready == 0) ? 32'd0 : res;
    en    = (r != 5'd0);
    reg_o = r;
    data  = res_eff;
`ifdef MULTDIV_EXC_EN
    if (exc_eff) begin
      en    = 1'b1;
      reg_o = 5'd30;
      data  = is_div ? 32'd5 : 32'd4;
    end
`else
    if (exc_eff && 1'b0) en = 1'b0;
`endif
  endtask

  // Runs one instruction starting in an IDLE cycle; returns just after the
  // edge that ends the WB cycle with an unrelated instruction on the bus.
  task automatic run_op(input bit is_div, input logic [4:0] r, input int n_ready,
                        input bit exc, input logic [31:0] res, input bit noise);
    int          n_wait;
    int          wb_cyc;
    bit          e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    n_wait = (n_ready == 0) ? 63 : n_ready;
    wb_cyc = n_wait + 3;
    model_wb(is_div, r, n_ready, exc, res, e_en, e_reg, e_data);
    drive_instr(is_div ? 2 : 1, r);
    for (int c = 1; c <= wb_cyc; c++) begin
      if (n_ready != 0 && c == n_ready + 2) begin
        md_ready     = 1'b1;
        md_exception = exc;
        md_result    = res;
      end else if (noise && c == 2) begin
        md_ready     = 1'b1;
        md_exception = 1'($urandom_range(0, 1));
        md_result    = $urandom;
      end else begin
        md_ready     = 1'b0;
        md_exception = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        md_result    = $urandom;
      end
      @(negedge clock);
      n_checks++;
      if (stall !== (c < wb_cyc)) begin
        n_errors++;
        $display("FAIL stall cycle=%0d got=%b exp=%b", c, stall, (c < wb_cyc));
      end
      n_checks++;
      if (ctrl_MULT !== (c == 2 && !is_div)) begin
        n_errors++;
        $display("FAIL ctrl_MULT cycle=%0d got=%b exp=%b", c, ctrl_MULT, (c == 2 && !is_div));
      end
      n_checks++;
      if (ctrl_DIV !== (c == 2 && is_div)) begin
        n_errors++;
        $display("FAIL ctrl_DIV cycle=%0d got=%b exp=%b", c, ctrl_DIV, (c == 2 && is_div));
      end
      n_checks++;
      if (wb_en !== (c == wb_cyc && e_en)) begin
        n_errors++;
        $display("FAIL wb_en cycle=%0d got=%b exp=%b", c, wb_en, (c == wb_cyc && e_en));
      end
      if (c == wb_cyc && e_en) begin
        n_checks++;
        if (wb_reg !== e_reg || wb_data !== e_data) begin
          n_errors++;
          $display("FAIL wb_target got reg=%0d data=%h exp reg=%0d data=%h",
                   wb_reg, wb_data, e_reg, e_data);
        end
      end
      @(posedge clock);
      #1;
    end
    md_ready = 1'b0;
    drive_instr(0, 5'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      md_ready  = 1'($urandom_range(0, 1));
      md_result = $urandom;
      @(negedge clock);
      n_checks++;
      if (stall !== 1'b0 || wb_en !== 1'b0 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
        n_errors++;
        $display("FAIL idle got stall=%b wb_en=%b mult=%b div=%b exp all 0",
                 stall, wb_en, ctrl_MULT, ctrl_DIV);
      end
      @(posedge clock);
      #1;
    end
    md_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_instr(1, 5'd3);
    md_ready     = 1'b1;
    md_exception = 1'b1;
    md_result    = 32'hDEAD_BEEF;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if ({stall, ctrl_MULT, ctrl_DIV, wb_en} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl got stall/mult/div/wb_en=%b exp=0000",
               {stall, ctrl_MULT, ctrl_DIV, wb_en});
    end
    n_checks++;
    if (wb_reg !== 5'd0 || wb_data !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_wb got reg=%0d data=%h exp 0", wb_reg, wb_data);
    end
    @(posedge clock);
    #1;
    drive_instr(0, 5'd0);
    md_ready     = 1'b0;
    md_exception = 1'b0;
    reset        = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_mult_basic();
    run_op(1'b0, 5'd5, 16, 1'b0, 32'd42, 1'b0);
  endtask

  task automatic test_div_exception();
    run_op(1'b1, 5'd7, 10, 1'b1, 32'h0000_1234, 1'b1);
  endtask

  task automatic test_rd_zero();
    run_op(1'b0, 5'd0, 5, 1'b0, 32'd99, 1'b0);
  endtask

  task automatic test_timeout();
    run_op(1'b1, 5'd12, 0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_ready_at_limit();
    run_op(1'b0, 5'd3, 63, 1'b0, 32'd77, 1'b0);
    run_op(1'b1, 5'd4, 1, 1'b0, 32'hCAFE_0001, 1'b1);
  endtask

  task automatic test_reset_abort();
    drive_instr(1, 5'd9);
    md_ready = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_pre_stall got=%b exp=1", stall);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_instr(0, 5'd0);
    @(negedge clock);
    n_checks++;
    if (stall !== 1'b0 || wb_en !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_in_reset got stall=%b wb_en=%b exp 0 0", stall, wb_en);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle_cycles(6);
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 5'd10, 4, 1'b0, 32'h1111_2222, 1'b1);
    run_op(1'b0, 5'd11, 7, 1'b0, 32'h3333_4444, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit          is_div;
      logic [4:0]  r;
      int          n_ready;
      int          sel;
      is_div = 1'($urandom_range(0, 1));
      r      = 5'($urandom);
      if ($urandom_range(0, 3) == 0) r = 5'd0;
      sel = $urandom_range(0, 7);
      if (sel == 0)      n_ready = 0;
      else if (sel == 1) n_ready = 63;
      else               n_ready = $urandom_range(1, 40);
      run_op(is_div, r, n_ready, 1'($urandom_range(0, 1)), $urandom, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    md_result    = '0;
    drive_instr(0, 5'd0);
    test_reset();
    test_mult_basic();
    test_div_exception();
    test_rd_zero();
    test_timeout();
    test_ready_at_limit();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
